// File: rtl/fs_serial.sv
// Bit-serial full subtractor: computes a - b - bi one bit per clock, LSB first,
// through a single full-subtractor cell, then presents d/bo with a done pulse.
module fs_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             diff_bit;
    logic             brw_bit;
    logic             last_bit;

    function automatic logic cell_diff(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic cell_borrow(input logic x, input logic y, input logic z);
        return (~x & y) | (~x & z) | (y & z);
    endfunction

    assign diff_bit = cell_diff(a_sr[0], b_sr[0], brw);
    assign brw_bit  = cell_borrow(a_sr[0], b_sr[0], brw);
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bo     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        brw  <= bi;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    res_sr <= {diff_bit, res_sr[WIDTH-1:1]};
                    brw    <= brw_bit;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    // Counter parks at the last index; it is only cleared by the next accepted start.
                    if (last_bit) begin
                        d    <= {diff_bit, res_sr[WIDTH-1:1]};
                        bo   <= brw_bit;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fs_serial.sv
// Bench for fs_serial: fixed vectors, multi-cycle corner sequences and randomized
// operations on WIDTH=8 and WIDTH=2 instances against an arithmetic reference.
module tb_fs_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bi8 = 1'b0;
    logic       busy8, done8, bo8;
    logic [7:0] d8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       bi2 = 1'b0;
    logic       busy2, done2, bo2;
    logic [1:0] d2;

    fs_serial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bi(bi8),
        .busy(busy8), .done(done8), .d(d8), .bo(bo8)
    );

    fs_serial #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bi(bi2),
        .busy(busy2), .done(done2), .d(d2), .bo(bo2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: unsigned (WIDTH+1)-bit subtraction, top bit is the borrow-out.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic z);
        return {1'b0, x} - {1'b0, y} - 9'(z);
    endfunction

    function automatic logic [2:0] ref2(input logic [1:0] x, input logic [1:0] y, input logic z);
        return {1'b0, x} - {1'b0, y} - 3'(z);
    endfunction

    // One full operation on the 8-bit instance; caller guarantees it is idle.
    task automatic do8(input logic [7:0] xa, input logic [7:0] xb, input logic xbi,
                       output int lat, output logic [7:0] dq, output logic boq,
                       output logic busy_acc, output logic busy_run,
                       output logic done_after, output logic busy_after);
        start8 = 1'b1; a8 = xa; b8 = xb; bi8 = xbi;
        @(posedge clk); #1;
        busy_acc = busy8;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        lat = 0;
        busy_run = 1'b1;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            busy_run &= busy8;
        end
        dq = d8; boq = bo8;
        @(posedge clk); #1;
        done_after = done8; busy_after = busy8;
    endtask

    task automatic do2(input logic [1:0] xa, input logic [1:0] xb, input logic xbi,
                       output int lat, output logic [1:0] dq, output logic boq,
                       output logic done_after);
        start2 = 1'b1; a2 = xa; b2 = xb; bi2 = xbi;
        @(posedge clk); #1;
        start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); bi2 = 1'($urandom);
        lat = 0;
        while (!done2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        dq = d2; boq = bo2;
        @(posedge clk); #1;
        done_after = done2;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [7:0] dq;
        logic       boq, bacc, brun, dafter, bafter;
        logic [1:0] dq2;
        logic [8:0] e8;
        logic [2:0] e2;
        logic [7:0] ha[3], hb[3];
        logic       hbi[3];
        int         npulse, pulse_c;

        vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[4] = '{8'h07, 8'h03, 1'b0, 8'h04, 1'b0};
        vecs[5] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy8", 32'(busy8), 0);
        chk("rst done8", 32'(done8), 0);
        chk("rst d8", 32'(d8), 0);
        chk("rst bo8", 32'(bo8), 0);
        chk("rst busy2", 32'(busy2), 0);
        chk("rst d2", 32'(d2), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do8(vecs[i].a, vecs[i].b, vecs[i].bi, lat, dq, boq, bacc, brun, dafter, bafter);
            chk($sformatf("vec%0d d", i), 32'(dq), 32'(vecs[i].d));
            chk($sformatf("vec%0d bo", i), 32'(boq), 32'(vecs[i].bo));
            chk($sformatf("vec%0d latency", i), 32'(lat), 8);
            chk($sformatf("vec%0d busy at accept", i), 32'(bacc), 1);
            chk($sformatf("vec%0d busy during run", i), 32'(brun), 1);
            chk($sformatf("vec%0d done width", i), 32'(dafter), 0);
            chk($sformatf("vec%0d busy after", i), 32'(bafter), 0);
        end

        // Start during RUN is ignored
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bi8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        npulse = 0; pulse_c = -1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (done8) begin npulse++; pulse_c = c; end
            if (c == 2) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bi8 = 1'b0; end
            if (c == 3) start8 = 1'b0;
        end
        chk("ignored start pulses", 32'(npulse), 1);
        chk("ignored start pulse edge", 32'(pulse_c), 8);
        chk("ignored start d held", 32'(d8), 32'h0F);
        chk("ignored start busy", 32'(busy8), 0);

        // Start held high: accepts every WIDTH+2 edges
        ha[0] = 8'h35; hb[0] = 8'h12; hbi[0] = 1'b0;
        ha[1] = 8'h9C; hb[1] = 8'hC9; hbi[1] = 1'b1;
        ha[2] = 8'h01; hb[2] = 8'h02; hbi[2] = 1'b0;
        start8 = 1'b1; a8 = ha[0]; b8 = hb[0]; bi8 = hbi[0];
        @(posedge clk); #1;
        chk("held busy at first accept", 32'(busy8), 1);
        a8 = ha[1]; b8 = hb[1]; bi8 = hbi[1];
        for (int j = 0; j < 3; j++) begin
            for (int c = 1; c <= 10; c++) begin
                @(posedge clk); #1;
                if (c == 8) begin
                    e8 = ref8(ha[j], hb[j], hbi[j]);
                    chk($sformatf("held op%0d done", j), 32'(done8), 1);
                    chk($sformatf("held op%0d result", j), 32'({bo8, d8}), 32'(e8));
                end
                if (c == 9) begin
                    chk($sformatf("held op%0d done clear", j), 32'(done8), 0);
                    chk($sformatf("held op%0d busy gap", j), 32'(busy8), 0);
                    if (j == 2) start8 = 1'b0;
                end
                if (c == 10) begin
                    chk($sformatf("held op%0d next accept", j), 32'(busy8), (j < 2) ? 1 : 0);
                    if (j == 0) begin a8 = ha[2]; b8 = hb[2]; bi8 = hbi[2]; end
                end
            end
        end

        // Asynchronous reset mid-operation
        start8 = 1'b1; a8 = 8'h35; b8 = 8'h12; bi8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(busy8), 0);
        chk("async rst done", 32'(done8), 0);
        chk("async rst d", 32'(d8), 0);
        chk("async rst bo", 32'(bo8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done8) npulse++;
        end
        chk("no done after reset", 32'(npulse), 0);
        do8(8'h07, 8'h03, 1'b0, lat, dq, boq, bacc, brun, dafter, bafter);
        chk("post-reset d", 32'(dq), 32'h04);
        chk("post-reset bo", 32'(boq), 0);
        chk("post-reset latency", 32'(lat), 8);

        // Randomized, WIDTH=8
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rbi;
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            e8 = ref8(ra, rb, rbi);
            do8(ra, rb, rbi, lat, dq, boq, bacc, brun, dafter, bafter);
            chk($sformatf("rnd8 %0d %h-%h-%b", n, ra, rb, rbi), 32'({boq, dq}), 32'(e8));
            chk($sformatf("rnd8 %0d latency", n), 32'(lat), 8);
            chk($sformatf("rnd8 %0d done width", n), 32'(dafter), 0);
        end

        // Randomized, WIDTH=2
        for (int n = 0; n < 1000; n++) begin
            logic [1:0] ra, rb;
            logic       rbi;
            ra = 2'($urandom); rb = 2'($urandom); rbi = 1'($urandom);
            e2 = ref2(ra, rb, rbi);
            do2(ra, rb, rbi, lat, dq2, boq, dafter);
            chk($sformatf("rnd2 %0d %h-%h-%b", n, ra, rb, rbi), 32'({boq, dq2}), 32'(e2));
            chk($sformatf("rnd2 %0d latency", n), 32'(lat), 2);
            chk($sformatf("rnd2 %0d done width", n), 32'(dafter), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fs_serial.md
# fs_serial

Bit-serial full subtractor: the subtracting counterpart to the team's full-adder cells. It accepts two WIDTH-bit operands and a borrow-in on a start handshake. It then computes a − b − bi one bit per clock, LSB first, through a single full-subtractor cell. It presents the registered difference and borrow-out with a one-cycle done pulse. It sits beside the adder blocks as the area-minimal subtract path for the practice datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bi  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; d and bo valid from this cycle on.
- d  output  WIDTH  difference a − b − bi mod 2^WIDTH.
- bo  output  1  borrow-out; 1 iff a < b + bi (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Per-bit cell, with x = a-bit, y = b-bit, z = running borrow:
  - diff = x ^ y ^ z
  - borrow = (~x & y) | (~x & z) | (y & z)
- Internal registers:
  - operand shift registers for a and b (shift right, LSB processed first);
  - result shift register (shift right, diff entering at MSB);
  - running borrow register;
  - bit counter of ceil(log2(WIDTH)) bits.
- IDLE: when start = 1, capture a, b and bi (bi goes into the borrow register), clear the counter, go to RUN. Otherwise stay in IDLE.
- RUN: each edge processes one bit:
  - shift the diff into the result register;
  - update the borrow register;
  - shift both operand registers;
  - increment the counter.
  - On the edge processing bit WIDTH−1, load d from the completed result, load bo from the final borrow, and go to DONE.
- DONE: done = 1 for exactly this cycle; go to IDLE unconditionally on the next edge.
- start is ignored in RUN and DONE; it is not queued.
- a, b and bi may change freely after the capture edge without affecting the operation in flight.
- d and bo change only on the completion edge. They hold their value through IDLE until the next operation completes.
- Full-width arithmetic is unsigned. Signed use is the caller's job: overflow = (a[MSB] ^ b[MSB]) & (a[MSB] ^ d[MSB]).

## Timing
- Reset values: busy = 0, done = 0, d = 0, bo = 0. Counter, borrow, operand and result registers are all 0.
- start sampled high in IDLE at edge k:
  - busy = 1 from edge k;
  - d and bo update, and done = 1, from edge k+WIDTH;
  - done = 0 and busy = 0 from edge k+WIDTH+1.
- Earliest next accepted start is at edge k+WIDTH+2 (start held high in IDLE). Throughput is one operation per WIDTH+2 cycles.
- Reset mid-operation: rst_n low asynchronously forces all reset values immediately.
  - The operation in flight is discarded and done is not pulsed.
  - The first start after rst_n rises is accepted normally.
- Counter wrap: the counter reaches WIDTH−1 and is cleared on the next accepted start. It never wraps inside RUN.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Test plan
- WIDTH = 8, a = 0x35, b = 0x12, bi = 0, start at edge k -> done at edge k+8, d = 0x23, bo = 0; busy high edges k..k+8, low at k+9.
- a = 0x00, b = 0x01, bi = 0 -> d = 0xFF, bo = 1. Then a = 0x80, b = 0x80, bi = 1 -> d = 0xFF, bo = 1. Then a = 0xFF, b = 0x00, bi = 1 -> d = 0xFE, bo = 0.
- Start 0x10 − 0x01; at edge k+3 drive start = 1 with a = 0xAA, b = 0x55 -> only one done pulse at k+8 with d = 0x0F. The second request is not executed; d holds 0x0F afterwards.
- Start held high continuously with a sequence of operands -> accepts at edges k, k+10, k+20, ...; each done carries the correct difference of the operands captured at its own accept edge.
- rst_n pulsed low at edge k+4 of an operation -> busy, done, d and bo read 0 immediately and no done pulse appears. A following 0x07 − 0x03 returns d = 0x04, bo = 0.
- Randomized 1000 operations for WIDTH = 8 and WIDTH = 2, checked against {bo, d} = a − b − bi (WIDTH+1-bit unsigned two's-complement compare) -> zero mismatches; done is exactly one cycle wide every time.
